// File: rtl/dm_lsu.sv
// ============================================================================
// dm_lsu : byte/half/word load-store unit in front of a word-only data memory
// Rev 1.0
// ============================================================================
`default_nettype none

module dm_lsu #(
  parameter int unsigned DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] dm_a,
  output logic [31:0] dm_wd,
  output logic        dm_we,
  input  logic [31:0] dm_rd
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t      state, state_nx;
  logic        we_q, uns_q;
  logic [1:0]  size_q, lane_q;
  logic [15:0] wdata_q;
  logic        accept, acc_err;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_val, merged;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;

  always_comb begin
    acc_err = 1'b0;
    if (req_size == 2'b11)                            acc_err = 1'b1;
    if (req_size == 2'b01 && req_addr[0])             acc_err = 1'b1;
    if (req_size == 2'b10 && req_addr[1:0] != 2'b00)  acc_err = 1'b1;
    if ({2'b00, req_addr[31:2]} >= 32'(DEPTH))        acc_err = 1'b1;
  end

  // Little-endian lane extraction and merge on the word currently on dm_rd
  always_comb begin
    rd_byte  = dm_rd[{lane_q, 3'b000} +: 8];
    rd_half  = dm_rd[{lane_q[1], 4'b0000} +: 16];
    load_val = dm_rd;
    merged   = dm_rd;
    case (size_q)
      2'b00: begin
        load_val = uns_q ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
        merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
      end
      2'b01: begin
        load_val = uns_q ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
        merged[{lane_q[1], 4'b0000} +: 16] = wdata_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (acc_err)                              state_nx = RESP;
          else if (req_we && req_size == 2'b10)     state_nx = WR;
          else                                      state_nx = RD;
        end
      end
      RD:      state_nx = we_q ? WR : RESP;
      WR:      state_nx = RESP;
      RESP:    if (resp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      size_q     <= 2'b00;
      lane_q     <= 2'b00;
      wdata_q    <= 16'h0;
      dm_a       <= 32'h0;
      dm_wd      <= 32'h0;
      dm_we      <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            we_q    <= req_we;
            uns_q   <= req_unsigned;
            size_q  <= req_size;
            lane_q  <= req_addr[1:0];
            wdata_q <= req_wdata[15:0];
            dm_a    <= {2'b00, req_addr[31:2]};
            if (acc_err) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'h0;
            end else if (req_we && req_size == 2'b10) begin
              dm_we <= 1'b1;
              dm_wd <= req_wdata;
            end
          end
        end
        RD: begin
          if (we_q) begin
            dm_we <= 1'b1;
            dm_wd <= merged;
          end else begin
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= load_val;
          end
        end
        WR: begin
          dm_we      <= 1'b0;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= 32'h0;
        end
        RESP: begin
          if (resp_ready) resp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dm_lsu.sv
// ============================================================================
// tb_dm_lsu : directed self-checking bench for dm_lsu with a behavioural DM
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_dm_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] dm_a;
  logic [31:0] dm_wd;
  logic        dm_we;
  logic [31:0] dm_rd;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [256];
  logic        pl_en = 1'b0;
  logic [7:0]  pl_idx = 8'h0;
  logic [31:0] pl_val = 32'h0;
  int          we_cnt = 0;
  logic [31:0] last_wd = 32'h0;

  dm_lsu #(.DEPTH(256)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .dm_a(dm_a), .dm_wd(dm_wd), .dm_we(dm_we), .dm_rd(dm_rd)
  );

  always #5 clk = ~clk;

  // Behavioural synchronous-write / combinational-read data memory
  assign dm_rd = (dm_a < 32'd256) ? mem[dm_a[7:0]] : 32'h0;

  always @(posedge clk) begin
    if (dm_we)      mem[dm_a[7:0]] <= dm_wd;
    else if (pl_en) mem[pl_idx]    <= pl_val;
  end

  always @(posedge clk) begin
    if (dm_we) begin
      we_cnt  = we_cnt + 1;
      last_wd = dm_wd;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [7:0] idx, input logic [31:0] val);
    pl_idx = idx;
    pl_val = val;
    pl_en  = 1'b1;
    @(posedge clk); #1;
    pl_en  = 1'b0;
  endtask

  task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                        input int exp_lat, input logic [31:0] exp_rdata, input logic exp_err,
                        input logic [31:0] exp_word, input int hold);
    int lat;
    we_cnt       = 0;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    req_valid    = 1'b1;
    chk({tag, ".req_ready_idle"}, {31'h0, req_ready}, 32'h1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = 32'hDEAD_BEEF;
    req_wdata = 32'h5555_5555;
    lat = 1;
    chk({tag, ".dm_a"}, dm_a, {2'b00, addr[31:2]});
    while (!resp_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".rdata"}, resp_rdata, exp_rdata);
    chk({tag, ".err"}, {31'h0, resp_err}, {31'h0, exp_err});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, ".hold_valid"}, {31'h0, resp_valid}, 32'h1);
      chk({tag, ".hold_rdata"}, resp_rdata, exp_rdata);
      chk({tag, ".hold_ready"}, {31'h0, req_ready}, 32'h0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk({tag, ".valid_drop"}, {31'h0, resp_valid}, 32'h0);
    chk({tag, ".ready_back"}, {31'h0, req_ready}, 32'h1);
    chk({tag, ".we_cycles"}, 32'(we_cnt), (we && !exp_err) ? 32'd1 : 32'd0);
    if (we && !exp_err) chk({tag, ".dm_wd"}, last_wd, exp_word);
    if (addr[31:10] == 22'h0) chk({tag, ".mem"}, mem[addr[9:2]], exp_word);
  endtask

  initial begin
    #12;
    chk("rst.req_ready", {31'h0, req_ready}, 32'h1);
    chk("rst.resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst.dm_we", {31'h0, dm_we}, 32'h0);
    chk("rst.dm_a", dm_a, 32'h0);
    chk("rst.dm_wd", dm_wd, 32'h0);
    chk("rst.rdata", resp_rdata, 32'h0);
    chk("rst.err", {31'h0, resp_err}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // word load / store
    preload(8'd8, 32'h0000_0002);
    do_req("ldw", 0, 2'b10, 0, 32'h20, 0, 2, 32'h2, 0, 32'h2, 0);
    do_req("stw", 1, 2'b10, 0, 32'h20, 32'd42, 2, 32'h0, 0, 32'd42, 0);
    do_req("ldw42", 0, 2'b10, 0, 32'h20, 0, 2, 32'd42, 0, 32'd42, 0);

    // byte read-modify-write and byte loads
    preload(8'd8, 32'h1122_3344);
    do_req("stb", 1, 2'b00, 0, 32'h22, 32'hFFFF_FFAB, 3, 32'h0, 0, 32'h11AB_3344, 0);
    do_req("ldbs", 0, 2'b00, 0, 32'h22, 0, 2, 32'hFFFF_FFAB, 0, 32'h11AB_3344, 0);
    do_req("ldbu", 0, 2'b00, 1, 32'h22, 0, 2, 32'h0000_00AB, 0, 32'h11AB_3344, 0);
    do_req("ldb0", 0, 2'b00, 0, 32'h20, 0, 2, 32'h0000_0044, 0, 32'h11AB_3344, 0);
    do_req("stb3", 1, 2'b00, 0, 32'h23, 32'h0000_0077, 3, 32'h0, 0, 32'h77AB_3344, 0);

    // half loads and store
    preload(8'd8, 32'h8001_FFFE);
    do_req("ldhs", 0, 2'b01, 0, 32'h22, 0, 2, 32'hFFFF_8001, 0, 32'h8001_FFFE, 0);
    do_req("ldhu", 0, 2'b01, 1, 32'h20, 0, 2, 32'h0000_FFFE, 0, 32'h8001_FFFE, 0);
    do_req("sth", 1, 2'b01, 0, 32'h20, 32'hABCD_1234, 3, 32'h0, 0, 32'h8001_1234, 0);

    // errors
    do_req("e_word", 0, 2'b10, 0, 32'h22, 0, 1, 32'h0, 1, 32'h8001_1234, 0);
    do_req("e_half", 0, 2'b01, 0, 32'h21, 0, 1, 32'h0, 1, 32'h8001_1234, 0);
    do_req("e_size", 0, 2'b11, 0, 32'h20, 0, 1, 32'h0, 1, 32'h8001_1234, 0);
    do_req("e_range", 0, 2'b10, 0, 32'h400, 0, 1, 32'h0, 1, 32'h0, 0);
    do_req("e_stw", 1, 2'b10, 0, 32'h22, 32'h1, 1, 32'h0, 1, 32'h8001_1234, 0);

    // last valid word, then backpressure
    preload(8'd255, 32'hCAFE_F00D);
    do_req("ldlast", 0, 2'b10, 0, 32'h3FC, 0, 2, 32'hCAFE_F00D, 0, 32'hCAFE_F00D, 5);

    // reset while a byte store is in its write cycle
    preload(8'd8, 32'h1122_3344);
    req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h21; req_wdata = 32'h0000_00CD; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("rmw.in_wr", {31'h0, dm_we}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rmw.dm_we_drop", {31'h0, dm_we}, 32'h0);
    chk("rmw.resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rmw.req_ready", {31'h0, req_ready}, 32'h1);
    chk("rmw.dm_a", dm_a, 32'h0);
    chk("rmw.dm_wd", dm_wd, 32'h0);
    @(posedge clk); #1;
    chk("rmw.mem_old", mem[8], 32'h1122_3344);
    rst_n = 1'b1;
    do_req("ld_after", 0, 2'b10, 0, 32'h20, 0, 2, 32'h1122_3344, 0, 32'h1122_3344, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
